cache_fill_fsm: RTL and testbench

Miss-handling controller that sits directly beside the data/tag cache on the memory side. It consumes the cache's `miss_detected` and the missing address, and reads the full 16-byte block (8 × 16-bit words) from the multi-cycle main memory. It writes each returned word into the cache data array, then issues a single tag-array write that validates the block and clears the cache's miss latch. While it works, `fsm_busy` stalls the pipeline.

---
 rtl/cache_fill_fsm_pkg.sv | 20 ++
 rtl/cache_fill_fsm_if.sv | 36 +++
 rtl/cache_fill_fsm_fill_word_counter.sv | 41 ++++
 rtl/cache_fill_fsm.sv | 156 +++++++++++++++
 tb/tb_cache_fill_fsm.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/cache_fill_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_fill_pkg
// Description : Shared state encoding and address-offset constants for the
//               cache block-fill controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_fill_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2
    } fill_state_t;

    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int WORD_OFFSET_LSB   = 1;

endpackage
`default_nettype wire

// File: rtl/cache_fill_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_fill_fsm_if
// Description : Cache-side and memory-side signal bundle of the fill
//               controller; master is the controller, slave its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_fill_fsm_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  miss_detected;
    logic [ADDR_WIDTH-1:0] miss_address;
    logic                  memory_data_valid;
    logic [15:0]           memory_data;
    logic                  fsm_busy;
    logic                  memory_read_en;
    logic [ADDR_WIDTH-1:0] memory_address;
    logic                  write_data_array;
    logic                  write_tag_array;
    logic [ADDR_WIDTH-1:0] cache_address;
    logic [15:0]           cache_data;
    logic [15:0]           miss_count;

    modport master (
        input  miss_detected, miss_address, memory_data_valid, memory_data,
        output fsm_busy, memory_read_en, memory_address, write_data_array,
               write_tag_array, cache_address, cache_data, miss_count
    );

    modport slave (
        output miss_detected, miss_address, memory_data_valid, memory_data,
        input  fsm_busy, memory_read_en, memory_address, write_data_array,
               write_tag_array, cache_address, cache_data, miss_count
    );
endinterface
`default_nettype wire

// File: rtl/cache_fill_fsm_fill_word_counter.sv
`default_nettype none
// ============================================================================
// Module      : fill_word_counter
// Description : Width-parameterised up-counter with synchronous clear,
//               count enable and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fill_word_counter #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr,
    input  wire logic             en,
    output logic [WIDTH-1:0]      count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cache_fill_fsm
// Description : Cache miss fill controller: reads a full block from main
//               memory, writes each word into the data array, then issues one
//               tag write. Optional fill counter: CACHE_FILL_MISS_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_fill_fsm
    import cache_fill_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int BLOCK_WORDS = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    cache_fill_fsm_if.master bus
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [CNT_W-1:0]      CNT_FULL   = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK = ~ADDR_WIDTH'((1 << BLOCK_OFFSET_BITS) - 1);

    fill_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q,  base_d;

    logic [CNT_W-1:0]      issue_cnt;
    logic [CNT_W-1:0]      recv_cnt;
    logic                  cnt_clr;
    logic                  issue_en;
    logic                  recv_en;
    logic [ADDR_WIDTH-1:0] issue_off;
    logic [ADDR_WIDTH-1:0] recv_off;

    logic                  busy;
    logic                  read_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  wr_data;
    logic                  wr_tag;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [15:0]           c_data;

    // Counters restart on the IDLE->FILL transition so every fill starts at word 0.
    assign cnt_clr   = (state_q == IDLE) && bus.miss_detected;
    assign issue_en  = (state_q == FILL) && (issue_cnt < CNT_FULL);
    assign recv_en   = (state_q == FILL) && bus.memory_data_valid;
    assign issue_off = ADDR_WIDTH'(issue_cnt[IDX_W-1:0]) << WORD_OFFSET_LSB;
    assign recv_off  = ADDR_WIDTH'(recv_cnt[IDX_W-1:0]) << WORD_OFFSET_LSB;

    fill_word_counter #(.WIDTH(CNT_W)) u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (issue_en),
        .count (issue_cnt)
    );

    fill_word_counter #(.WIDTH(CNT_W)) u_recv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (recv_en),
        .count (recv_cnt)
    );

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        busy     = 1'b0;
        read_en  = 1'b0;
        mem_addr = '0;
        wr_data  = 1'b0;
        wr_tag   = 1'b0;
        c_addr   = '0;
        c_data   = '0;
        case (state_q)
            IDLE: begin
                if (bus.miss_detected) begin
                    base_d  = bus.miss_address & BLOCK_MASK;
                    state_d = FILL;
                end
            end
            FILL: begin
                busy = 1'b1;
                if (issue_cnt < CNT_FULL) begin
                    read_en  = 1'b1;
                    mem_addr = base_q | issue_off;
                end
                if (bus.memory_data_valid) begin
                    wr_data = 1'b1;
                    c_addr  = base_q | recv_off;
                    c_data  = bus.memory_data;
                    if (recv_cnt == CNT_LAST) begin
                        state_d = TAG;
                    end
                end
            end
            TAG: begin
                busy    = 1'b1;
                wr_tag  = 1'b1;
                c_addr  = base_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

    assign bus.fsm_busy         = busy;
    assign bus.memory_read_en   = read_en;
    assign bus.memory_address   = mem_addr;
    assign bus.write_data_array = wr_data;
    assign bus.write_tag_array  = wr_tag;
    assign bus.cache_address    = c_addr;
    assign bus.cache_data       = c_data;

`ifdef CACHE_FILL_MISS_COUNT_EN
    logic [15:0] miss_count_q, miss_count_d;

    // Saturating count of completed fills; only rst clears it.
    always_comb begin
        miss_count_d = miss_count_q;
        if ((state_q == TAG) && (miss_count_q != 16'hFFFF)) begin
            miss_count_d = miss_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_count_q <= '0;
        end else begin
            miss_count_q <= miss_count_d;
        end
    end

    assign bus.miss_count = miss_count_q;
`else
    assign bus.miss_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_fill_fsm
// Description : Scoreboard bench for cache_fill_fsm with directed fills.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_fill_fsm;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cache_fill_fsm_if #(.ADDR_WIDTH(16)) bus ();

    cache_fill_fsm #(.ADDR_WIDTH(16), .BLOCK_WORDS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int fills    = 0;

    logic [15:0] exp_rd_q[$];
    logic [15:0] exp_wa_q[$];
    logic [15:0] exp_wd_q[$];
    logic [15:0] exp_tag_q[$];

    localparam logic [31:0] MASK_L4    = 32'h0000_1FE0; // valid in cycles 5..12
    localparam logic [31:0] MASK_L1    = 32'h0000_03FC; // valid in cycles 2..9
    localparam logic [31:0] MASK_GAPPY = 32'h0011_B160; // 5,6,8,12,13,15,16,20

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] word_data(input logic [15:0] base, input int i);
        return {base[11:4], 5'b0, 3'(i)} ^ 16'hC3A5;
    endfunction

    function automatic logic [71:0] all_outputs();
        return {4'b0, bus.fsm_busy, bus.memory_read_en, bus.memory_address,
                bus.write_data_array, bus.write_tag_array, bus.cache_address,
                bus.cache_data, bus.miss_count};
    endfunction

    function automatic logic [15:0] exp_count();
`ifdef CACHE_FILL_MISS_COUNT_EN
        return 16'(fills);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops an expectation whenever the DUT presents an action.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.memory_read_en) begin
                if (exp_rd_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rd_unexpected: got read of %0h expected none", bus.memory_address);
                end else begin
                    check("rd_addr", bus.memory_address, exp_rd_q.pop_front());
                end
            end
            if (bus.write_data_array) begin
                if (exp_wa_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL wr_unexpected: got write to %0h expected none", bus.cache_address);
                end else begin
                    check("wr_addr", bus.cache_address, exp_wa_q.pop_front());
                    check("wr_data", bus.cache_data, exp_wd_q.pop_front());
                end
            end
            if (bus.write_tag_array) begin
                if (exp_tag_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL tag_unexpected: got tag write %0h expected none", bus.cache_address);
                end else begin
                    check("tag_addr", bus.cache_address, exp_tag_q.pop_front());
                end
            end
        end
    end

    // One fill: miss in cycle 0, memory returns per vmask bit c, optional held
    // miss, optional reset after abort_after data returns.
    task automatic run_fill(input logic [15:0] addr, input logic [31:0] vmask,
                            input bit hold, input int abort_after);
        logic [15:0] base;
        int nvalid;
        int seen;
        int tag_c;
        base   = {addr[15:4], 4'h0};
        nvalid = 0;
        seen   = 0;
        tag_c  = 0;
        for (int c = 1; c < 32; c++) begin
            if (vmask[c]) begin
                seen++;
                if (seen == 8) tag_c = c + 1;
            end
        end
        for (int i = 0; i < 8; i++) begin
            exp_rd_q.push_back(base | 16'(i << 1));
            exp_wa_q.push_back(base | 16'(i << 1));
            exp_wd_q.push_back(word_data(base, i));
        end
        exp_tag_q.push_back(base);

        tick();
        bus.miss_detected     = 1'b1;
        bus.miss_address      = addr;
        bus.memory_data_valid = 1'b0;
        @(negedge clk);
        check("busy_c0", bus.fsm_busy, 1'b0);

        for (int c = 1; c <= 40; c++) begin
            tick();
            if (abort_after > 0 && nvalid == abort_after) begin
                rst                   = 1'b1;
                bus.miss_detected     = 1'b0;
                bus.memory_data_valid = 1'b0;
                @(negedge clk);
                check("reset_midfill_zero", all_outputs(), '0);
                exp_rd_q.delete();
                exp_wa_q.delete();
                exp_wd_q.delete();
                exp_tag_q.delete();
                fills = 0;
                tick();
                rst = 1'b0;
                @(negedge clk);
                check("reset_count_zero", bus.miss_count, 16'h0000);
                return;
            end
            bus.miss_detected     = hold && (c <= tag_c);
            bus.memory_data_valid = vmask[c];
            bus.memory_data       = vmask[c] ? word_data(base, nvalid) : 16'hDEAD;
            if (vmask[c]) nvalid++;
            @(negedge clk);
            check("busy", bus.fsm_busy, c <= tag_c);
            check("read_en", bus.memory_read_en, c <= 8);
            check("tag_cycle", bus.write_tag_array, c == tag_c);
            if (c == tag_c + 1) begin
                fills++;
                break;
            end
        end
        bus.miss_detected = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst                   = 1'b1;
        bus.miss_detected     = 1'b0;
        bus.miss_address      = '0;
        bus.memory_data_valid = 1'b0;
        bus.memory_data       = '0;

        for (int i = 0; i < 4; i++) begin
            tick();
            bus.miss_detected     = 1'($urandom_range(0, 1));
            bus.miss_address      = 16'($urandom);
            bus.memory_data_valid = 1'($urandom_range(0, 1));
            bus.memory_data       = 16'($urandom);
            @(negedge clk);
            check("reset_zero", all_outputs(), '0);
        end

        tick();
        rst                   = 1'b0;
        bus.miss_detected     = 1'b0;
        bus.memory_data_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("idle_valid_no_write", bus.write_data_array, 1'b0);
            check("idle_zero", all_outputs(), '0);
            tick();
        end
        bus.memory_data_valid = 1'b0;

        run_fill(16'h1A36, MASK_L4, 1'b0, 0);
        run_fill(16'h2B5E, MASK_GAPPY, 1'b0, 0);
        run_fill(16'h7FF2, MASK_L1, 1'b1, 0);
        @(negedge clk);
        check("miss_count_3", bus.miss_count, exp_count());
        run_fill(16'h0ABC, MASK_L4, 1'b1, 0);
        run_fill(16'h3C48, MASK_L4, 1'b0, 3);
        run_fill(16'h0040, MASK_L4, 1'b0, 0);
        @(negedge clk);
        check("miss_count_after_reset", bus.miss_count, exp_count());
        check("scoreboard_drained",
              exp_rd_q.size() + exp_wa_q.size() + exp_tag_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
